chnlnk_evt_sched: RTL and testbench
===================================

# chnlnk_evt_sched

Event readout scheduler for the channel-link framer. It queues L1A events (each tagged with a sample-block count) and presents the framer with the `L1A_BUF_MT`, `F_MT` and `END_EVT` controls it expects. It shares the single framer among `NSRC` sample-block FIFOs, granting them round-robin one frame at a time. It sits between the L1A/sample-FIFO logic and the framer.

## Interface
- `NSRC`, default 4: number of sample-block FIFOs; power of 2, range 2–8.
- `QDEPTH`, default 8: event-queue depth; power of 2.
- `CLK`  in  1: clock.
- `RST`  in  1: reset, asynchronous, active-high.
- `L1A_PUSH`  in  1: one-cycle strobe; enqueue an event.
- `L1A_NBLK`  in  4: frame count for the event, sampled with `L1A_PUSH`; 0 is treated as 1.
- `SRC_MT`  in  NSRC: per-FIFO empty flags.
- `FRM_RD`  in  1: framer read strobe.
- `FRM_BLK_DONE`  in  1: one-cycle pulse when the framer finishes a frame (seqn 99 reached).
- `FRM_EVT_DONE`  in  1: one-cycle pulse when the framer asserts its last-word output.
- `L1A_BUF_MT`  out  1: event queue empty; drives the framer.
- `F_MT`  out  1: empty flag of the granted FIFO, gated; drives the framer.
- `END_EVT`  out  1: the current frame is the last frame of the event.
- `SRC_RD`  out  NSRC: `FRM_RD` steered to the granted FIFO.
- `GRANT`  out  log2(NSRC): index of the granted FIFO.
- `EVT_CNT`  out  16: number of completed events; wraps at 0xFFFF → 0.
- `OVFL`  out  1: sticky; a push was dropped because the queue was full.
- `SEQ_ERR`  out  1: sticky; a framer done-pulse arrived outside its valid state.

## Operation
- **Event queue:** FIFO of `L1A_NBLK` values, `QDEPTH` entries. `L1A_BUF_MT` = (queue count == 0), registered.
- **Push while full without a pop:** the push is dropped and `OVFL` is set. Push and pop in the same cycle when full: both are accepted and the count is unchanged.
- **Remaining-frame counter:** `rem`, 4 bits.
- **Round-robin pointer:** `GRANT` persists across events. It advances by 1 mod `NSRC` on every accepted `FRM_BLK_DONE`.
- **State machine:** IDLE, LOAD, ACTIVE, WAIT_END.
  - IDLE: if the queue is non-empty, go to LOAD.
  - LOAD, one cycle: `rem` ← head value (0 becomes 1). Go to ACTIVE.
  - ACTIVE, on `FRM_BLK_DONE`: if `rem` == 1, go to WAIT_END. Otherwise decrement `rem` and stay. `GRANT` advances in both cases.
  - WAIT_END, on `FRM_EVT_DONE`: pop the queue, increment `EVT_CNT`, go to IDLE.
- **Framer-facing outputs:**
  - `F_MT` = `SRC_MT[GRANT]` in ACTIVE, and 1 in every other state.
  - `END_EVT` = (state == ACTIVE && `rem` == 1).
  - `SRC_RD[i]` = `FRM_RD` && (i == `GRANT`) && state == ACTIVE. This is combinational.
- **Protocol errors:** `FRM_BLK_DONE` outside ACTIVE, or `FRM_EVT_DONE` outside WAIT_END, sets `SEQ_ERR`. The pulse is otherwise ignored.
- **Reset values:** `L1A_BUF_MT`=1, `F_MT`=1, `END_EVT`=0, `SRC_RD`=0, `GRANT`=0, `EVT_CNT`=0, `OVFL`=0, `SEQ_ERR`=0. State = IDLE, queue empty, `rem`=0.
- **Reset mid-event:** the queue is flushed and the in-flight event is abandoned without counting. The framer is reset by the same `RST`.

## Timing
- `L1A_PUSH` at edge n: queue count updates at n+1. `L1A_BUF_MT` falls at n+1.
- From IDLE with a non-empty queue: LOAD at +1, ACTIVE at +2. `F_MT` reflects `SRC_MT[GRANT]` from +2.
- `FRM_BLK_DONE` at edge n: `GRANT` and `rem` update at n+1. `END_EVT` is valid from n+1, well before the framer's seqn-95 decision.
- `FRM_EVT_DONE` at edge n: pop takes effect at n+1. `L1A_BUF_MT` returns to 1 at n+1 if that was the last entry.
- `SRC_RD` has zero latency from `FRM_RD`.
- All outputs except `SRC_RD` are registered.

## Test plan
- **Single event, 1 frame:** reset, push `NBLK`=1, `SRC_MT`=0. `END_EVT`=1 throughout ACTIVE, `GRANT` 0→1 after the done-pulse, `EVT_CNT`=1, `L1A_BUF_MT`=1 at the end.
- **Multi-frame rotation:** push `NBLK`=6, `NSRC`=4. `GRANT` sequence 0,1,2,3,0,1. `END_EVT` is high only during the 6th frame. Final `GRANT`=2.
- **Back-to-back events:** push `NBLK`=2 and then `NBLK`=3 on consecutive cycles. Second event starts with `GRANT`=2. `L1A_BUF_MT` stays 0 until the 2nd `FRM_EVT_DONE`. `EVT_CNT`=2.
- **Overflow:** push 9 events with no pops. `OVFL`=1 after the 9th push, and exactly 8 events are later read out. Also check push and pop in the same cycle at full: count stays 8, `OVFL` unchanged.
- **Errors and gating:** `FRM_EVT_DONE` pulsed in ACTIVE sets `SEQ_ERR`=1 with state unchanged. `SRC_MT[GRANT]`=1 forces `F_MT`=1. `FRM_RD` pulses reach only `SRC_RD[GRANT]`.
- **Reset mid-event:** assert `RST` in ACTIVE with `rem`=3. All outputs return to their reset values immediately, and the queue is empty after reset is released.

Source files
------------

// File: rtl/chnlnk_evt_sched.sv
// ============================================================================
// Module   : chnlnk_evt_sched
// Purpose  : L1A event queue and round-robin frame scheduler for the framer.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module chnlnk_evt_sched #(
  parameter int NSRC   = 4,
  parameter int QDEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_l1a_push,
  input  logic [3:0]                i_l1a_nblk,
  input  logic [NSRC-1:0]           i_src_mt,
  input  logic                      i_frm_rd,
  input  logic                      i_frm_blk_done,
  input  logic                      i_frm_evt_done,
  output logic                      o_l1a_buf_mt,
  output logic                      o_f_mt,
  output logic                      o_end_evt,
  output logic [NSRC-1:0]           o_src_rd,
  output logic [$clog2(NSRC)-1:0]   o_grant,
  output logic [15:0]               o_evt_cnt,
  output logic                      o_ovfl,
  output logic                      o_seq_err
);

  localparam int GW    = $clog2(NSRC);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_WAIT_END = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_rem;
  logic [3:0]       w_rem_nxt;
  logic [3:0]       w_head;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    w_grant_nxt;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_blk_ok;
  logic             r_buf_mt;
  logic             r_f_mt;
  logic             r_end_evt;
  logic [15:0]      r_evt_cnt;
  logic             r_ovfl;
  logic             r_seq_err;
  logic             w_f_mt_nxt;
  logic             w_end_evt_nxt;
  logic [NSRC-1:0]  w_src_rd;

  // A pop frees a slot in the same cycle, so a push at full is still accepted.
  assign w_full    = (r_cnt == CNT_W'(QDEPTH));
  assign w_pop     = (r_state == S_WAIT_END) && i_frm_evt_done;
  assign w_push_ok = i_l1a_push && (!w_full || w_pop);
  assign w_blk_ok  = (r_state == S_ACTIVE) && i_frm_blk_done;
  assign w_head    = r_mem[r_rptr];

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push_ok, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_l1a_nblk;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (r_cnt != '0) w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = S_ACTIVE;
      S_ACTIVE:   if (w_blk_ok && (r_rem == 4'd1)) w_state_nxt = S_WAIT_END;
      S_WAIT_END: if (i_frm_evt_done) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rem_nxt   = r_rem;
    w_grant_nxt = r_grant;
    if (r_state == S_LOAD) begin
      w_rem_nxt = (w_head == 4'd0) ? 4'd1 : w_head;
    end else if (w_blk_ok && (r_rem != 4'd1)) begin
      w_rem_nxt = r_rem - 4'd1;
    end
    // NSRC is a power of two, so the pointer wraps naturally.
    if (w_blk_ok) begin
      w_grant_nxt = r_grant + GW'(1);
    end
  end

  // Output decode: framer flags are computed from the next state so their
  // registered copies line up with the state they describe.
  always_comb begin
    w_f_mt_nxt    = 1'b1;
    w_end_evt_nxt = 1'b0;
    w_src_rd      = '0;
    if (w_state_nxt == S_ACTIVE) begin
      w_f_mt_nxt    = i_src_mt[w_grant_nxt];
      w_end_evt_nxt = (w_rem_nxt == 4'd1);
    end
    if ((r_state == S_ACTIVE) && i_frm_rd) begin
      w_src_rd[r_grant] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rem     <= 4'd0;
      r_grant   <= '0;
      r_buf_mt  <= 1'b1;
      r_f_mt    <= 1'b1;
      r_end_evt <= 1'b0;
      r_evt_cnt <= 16'd0;
      r_ovfl    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_rem     <= w_rem_nxt;
      r_grant   <= w_grant_nxt;
      r_buf_mt  <= (w_cnt_nxt == '0);
      r_f_mt    <= w_f_mt_nxt;
      r_end_evt <= w_end_evt_nxt;
      if (w_pop) begin
        r_evt_cnt <= r_evt_cnt + 16'd1;
      end
      if (i_l1a_push && w_full && !w_pop) begin
        r_ovfl <= 1'b1;
      end
      if ((i_frm_blk_done && (r_state != S_ACTIVE)) ||
          (i_frm_evt_done && (r_state != S_WAIT_END))) begin
        r_seq_err <= 1'b1;
      end
    end
  end

  assign o_l1a_buf_mt = r_buf_mt;
  assign o_f_mt       = r_f_mt;
  assign o_end_evt    = r_end_evt;
  assign o_src_rd     = w_src_rd;
  assign o_grant      = r_grant;
  assign o_evt_cnt    = r_evt_cnt;
  assign o_ovfl       = r_ovfl;
  assign o_seq_err    = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_chnlnk_evt_sched.sv
// ============================================================================
// Module   : tb_chnlnk_evt_sched
// Purpose  : Directed vector bench for chnlnk_evt_sched (NSRC=4, QDEPTH=8).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chnlnk_evt_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        l1a_push = 1'b0;
  logic [3:0]  l1a_nblk = 4'd0;
  logic [3:0]  src_mt = 4'd0;
  logic        frm_rd = 1'b0;
  logic        blk_done = 1'b0;
  logic        evt_done = 1'b0;
  logic        buf_mt;
  logic        f_mt;
  logic        end_evt;
  logic [3:0]  src_rd;
  logic [1:0]  grant;
  logic [15:0] evt_cnt;
  logic        ovfl;
  logic        seq_err;

  int n_checks = 0;
  int n_errs   = 0;

  chnlnk_evt_sched #(.NSRC(4), .QDEPTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_l1a_push     (l1a_push),
    .i_l1a_nblk     (l1a_nblk),
    .i_src_mt       (src_mt),
    .i_frm_rd       (frm_rd),
    .i_frm_blk_done (blk_done),
    .i_frm_evt_done (evt_done),
    .o_l1a_buf_mt   (buf_mt),
    .o_f_mt         (f_mt),
    .o_end_evt      (end_evt),
    .o_src_rd       (src_rd),
    .o_grant        (grant),
    .o_evt_cnt      (evt_cnt),
    .o_ovfl         (ovfl),
    .o_seq_err      (seq_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        push;
    logic [3:0]  nblk;
    logic [3:0]  smt;
    logic        rd;
    logic        bd;
    logic        ed;
    logic        e_bmt;
    logic        e_fmt;
    logic        e_end;
    logic [3:0]  e_rd;
    logic [1:0]  e_g;
    logic [15:0] e_cnt;
    logic        e_serr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic p, logic [3:0] n, logic [3:0] sm,
                              logic rd, logic bd, logic ed, logic bmt,
                              logic fmt, logic ee, logic [3:0] rdo,
                              logic [1:0] g, logic [15:0] c, logic se);
    vec_t v;
    v.rst = r; v.push = p; v.nblk = n; v.smt = sm; v.rd = rd; v.bd = bd;
    v.ed = ed; v.e_bmt = bmt; v.e_fmt = fmt; v.e_end = ee; v.e_rd = rdo;
    v.e_g = g; v.e_cnt = c; v.e_serr = se;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    l1a_push = 1'b0; blk_done = 1'b0; evt_done = 1'b0; frm_rd = 1'b0; src_mt = 4'd0;
    RST = 1'b1;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic push1(input logic [3:0] n);
    l1a_push = 1'b1; l1a_nblk = n;
    cyc();
    l1a_push = 1'b0;
  endtask

  task automatic pulse_bd();
    blk_done = 1'b1;
    cyc();
    blk_done = 1'b0;
  endtask

  task automatic pulse_ed();
    evt_done = 1'b1;
    cyc();
    evt_done = 1'b0;
  endtask

  // ACTIVE is recognised by F_MT dropping while every source reports data.
  task automatic wait_act(input string tag);
    int n = 0;
    while (f_mt !== 1'b0 && n < 20) begin
      cyc();
      n++;
    end
    if (f_mt !== 1'b0) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: timeout waiting for ACTIVE, f_mt %0h expected 0", tag, f_mt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //       rst p  nb    smt     rd bd ed | bmt fmt end rdo     g  cnt serr
    tbl.push_back(mk(0, 1, 4'd1, 4'b0000, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 1, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 1, 0, 1, 0, 4'b0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 1, 1, 0, 4'b0000, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'd0, 4'b0000, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'd6, 4'b0000, 0, 0, 0, 1, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0100, 1, 1, 0, 0, 0, 0, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0100, 1, 1, 0, 0, 1, 0, 4'b0100, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 1, 1, 0, 0, 0, 0, 4'b1000, 3, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 1, 1, 0, 0, 0, 1, 4'b0010, 1, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 1, 0, 1, 0, 1, 0, 4'b0000, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4'd0, 4'b0000, 0, 0, 0, 1, 1, 0, 4'b0000, 2, 1, 0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      RST = tbl[i].rst; l1a_push = tbl[i].push; l1a_nblk = tbl[i].nblk;
      src_mt = tbl[i].smt; frm_rd = tbl[i].rd; blk_done = tbl[i].bd;
      evt_done = tbl[i].ed;
      #2;
      chk($sformatf("v%0d.buf_mt", i),  buf_mt,  tbl[i].e_bmt);
      chk($sformatf("v%0d.f_mt", i),    f_mt,    tbl[i].e_fmt);
      chk($sformatf("v%0d.end_evt", i), end_evt, tbl[i].e_end);
      chk($sformatf("v%0d.src_rd", i),  src_rd,  tbl[i].e_rd);
      chk($sformatf("v%0d.grant", i),   grant,   tbl[i].e_g);
      chk($sformatf("v%0d.evt_cnt", i), evt_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d.seq_err", i), seq_err, tbl[i].e_serr);
      @(posedge CLK);
      #1;
    end
    RST = 1'b0; l1a_push = 1'b0; frm_rd = 1'b0; blk_done = 1'b0; evt_done = 1'b0;

    // Back-to-back events: 2 frames then 3 frames.
    do_reset();
    push1(4'd2);
    push1(4'd3);
    chk("b2b.buf_mt_after_push", buf_mt, 0);
    wait_act("b2b.ev1");
    chk("b2b.ev1_grant", grant, 0);
    chk("b2b.ev1_end0", end_evt, 0);
    pulse_bd();
    chk("b2b.ev1_end1", end_evt, 1);
    pulse_bd();
    chk("b2b.ev1_grant_done", grant, 2);
    pulse_ed();
    chk("b2b.cnt1", evt_cnt, 1);
    chk("b2b.buf_mt_mid", buf_mt, 0);
    wait_act("b2b.ev2");
    chk("b2b.ev2_grant", grant, 2);
    for (int k = 0; k < 3; k++) pulse_bd();
    chk("b2b.ev2_grant_done", grant, 1);
    pulse_ed();
    chk("b2b.cnt2", evt_cnt, 2);
    chk("b2b.buf_mt_end", buf_mt, 1);
    chk("b2b.seq_err", seq_err, 0);

    // Overflow and simultaneous push/pop at full.
    do_reset();
    for (int k = 0; k < 8; k++) push1(4'd1);
    chk("ovf.after8", ovfl, 0);
    pulse_bd();
    l1a_push = 1'b1; l1a_nblk = 4'd1; evt_done = 1'b1;
    cyc();
    l1a_push = 1'b0; evt_done = 1'b0;
    chk("ovf.pushpop_ovfl", ovfl, 0);
    chk("ovf.pushpop_cnt", evt_cnt, 1);
    push1(4'd1);
    chk("ovf.dropped", ovfl, 1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("ovf.buf_mt_before_last", buf_mt, 0);
      wait_act($sformatf("ovf.rd%0d", k));
      pulse_bd();
      pulse_ed();
    end
    chk("ovf.evt_cnt", evt_cnt, 9);
    chk("ovf.buf_mt_empty", buf_mt, 1);
    cyc(); cyc(); cyc();
    chk("ovf.stays_idle", f_mt, 1);
    chk("ovf.seq_err", seq_err, 0);

    // Protocol errors and gating.
    do_reset();
    pulse_bd();
    chk("err.bd_in_idle", seq_err, 1);
    do_reset();
    chk("err.reset_clears", seq_err, 0);
    push1(4'd3);
    wait_act("err.act");
    pulse_ed();
    chk("err.ed_in_active", seq_err, 1);
    chk("err.still_active", f_mt, 0);
    chk("err.end0", end_evt, 0);
    pulse_bd();
    pulse_bd();
    chk("err.end_after2", end_evt, 1);
    chk("err.grant", grant, 2);
    src_mt = 4'b0100;
    cyc();
    chk("gate.f_mt_forced", f_mt, 1);
    src_mt = 4'b1011;
    cyc();
    chk("gate.f_mt_granted", f_mt, 0);
    src_mt = 4'b0000;
    frm_rd = 1'b1;
    #1;
    chk("gate.src_rd", src_rd, 4'b0100);
    frm_rd = 1'b0;

    // Reset in the middle of an event with rem=3.
    do_reset();
    push1(4'd4);
    wait_act("rst.act");
    pulse_bd();
    chk("rst.grant_before", grant, 1);
    chk("rst.end_before", end_evt, 0);
    frm_rd = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst.buf_mt", buf_mt, 1);
    chk("rst.f_mt", f_mt, 1);
    chk("rst.end_evt", end_evt, 0);
    chk("rst.src_rd", src_rd, 0);
    chk("rst.grant", grant, 0);
    chk("rst.evt_cnt", evt_cnt, 0);
    chk("rst.ovfl", ovfl, 0);
    chk("rst.seq_err", seq_err, 0);
    frm_rd = 1'b0;
    cyc();
    RST = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    chk("rst.queue_empty", buf_mt, 1);
    chk("rst.idle_after", f_mt, 1);
    chk("rst.no_count", evt_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
